// File: rtl/traffic_eval_pkg.sv
// traffic_eval_pkg: shared types for the traffic-eval ingress path.
// Flit, buffered entry and packet-framing state.
package traffic_eval_pkg;

  typedef struct packed {
    logic        head;
    logic        tail;
    logic [63:0] egress_id;
    logic [63:0] unique_id;
  } flit_t;

  typedef struct packed {
    flit_t       flit;
    logic [63:0] inject_cycle;
  } entry_t;

  typedef enum logic {
    IDLE,
    BODY
  } pkt_state_e;

endpackage

// File: rtl/traffic_eval_fifo.sv
// traffic_eval_fifo: small synchronous FIFO with wrap-bit pointers.
// Read data is the head entry, combinational from storage.
module traffic_eval_fifo
  import traffic_eval_pkg::*;
#(
  parameter type T     = entry_t,
  parameter int  DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage and pointers; storage cleared so idle outputs read zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/traffic_eval_ingress_adapter.sv
// traffic_eval_ingress_adapter: buffers source flits, checks framing,
// and sends them to a NoC port under credit flow control.
module traffic_eval_ingress_adapter
  import traffic_eval_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_CREDITS = 4,
  parameter int CW          = $clog2(NUM_CREDITS+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [63:0]   current_cycle,
  output logic          in_ready,
  input  logic          in_valid,
  input  logic          in_head,
  input  logic          in_tail,
  input  logic [63:0]   in_egress_id,
  input  logic [63:0]   in_unique_id,
  output logic          out_valid,
  output logic          out_head,
  output logic          out_tail,
  output logic [63:0]   out_egress_id,
  output logic [63:0]   out_unique_id,
  output logic [63:0]   out_inject_cycle,
  input  logic          credit_return,
  output logic [CW-1:0] credits_avail,
  output logic          protocol_error,
  output logic          credit_overflow,
  output logic [63:0]   flits_sent
);

  localparam logic [CW-1:0] CMAX = CW'(NUM_CREDITS);

  logic       full;
  logic       empty;
  logic       accept;
  logic       push;
  logic       send;
  logic       err;
  logic       match;
  entry_t     wdata;
  entry_t     rdata;
  pkt_state_e state_q;
  pkt_state_e state_d;
  logic [63:0] egress_q;
  logic [63:0] egress_d;
  logic [CW-1:0] credits_q;

  assign in_ready = reset && !full;
  assign accept   = in_valid && in_ready;
  assign send     = !empty && (credits_q != '0);
  assign match    = !in_head && (in_egress_id == egress_q);
  assign wdata    = {in_head, in_tail, in_egress_id,
                     in_unique_id, current_cycle};

  assign out_valid        = send;
  assign out_head         = rdata.flit.head;
  assign out_tail         = rdata.flit.tail;
  assign out_egress_id    = rdata.flit.egress_id;
  assign out_unique_id    = rdata.flit.unique_id;
  assign out_inject_cycle = rdata.inject_cycle;
  assign credits_avail    = credits_q;

  traffic_eval_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (send),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Packet framing: decide push/drop and next packet state.
  always_comb begin
    state_d  = state_q;
    egress_d = egress_q;
    push     = 1'b0;
    err      = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            !in_head: err = 1'b1;
            in_head && in_tail: push = 1'b1;
            in_head && !in_tail: begin
              push     = 1'b1;
              egress_d = in_egress_id;
              state_d  = BODY;
            end
            default: ;
          endcase
        end
        BODY: begin
          unique case (1'b1)
            !match: begin
              err     = 1'b1;
              state_d = IDLE;
            end
            match && in_tail: begin
              push    = 1'b1;
              state_d = IDLE;
            end
            match && !in_tail: push = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Packet state and latched egress of the open packet.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      egress_q <= '0;
    end else begin
      state_q  <= state_d;
      egress_q <= egress_d;
    end
  end

  // Credit counter, send counter and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credits_q       <= CMAX;
      credit_overflow <= 1'b0;
      protocol_error  <= 1'b0;
      flits_sent      <= '0;
    end else begin
      if (send && !credit_return) begin
        credits_q <= credits_q - CW'(1);
      end else if (!send && credit_return) begin
        if (credits_q == CMAX) credit_overflow <= 1'b1;
        else credits_q <= credits_q + CW'(1);
      end
      if (err) protocol_error <= 1'b1;
      flits_sent <= flits_sent + 64'(send);
    end
  end

endmodule

// File: tb/tb_traffic_eval_ingress_adapter.sv
// tb_traffic_eval_ingress_adapter: directed + random stimulus with a
// queue scoreboard and a cycle-level reference model.
module tb_traffic_eval_ingress_adapter;

  localparam int DEPTH = 4;
  localparam int NC    = 4;
  localparam int CW    = $clog2(NC+1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   current_cycle = 64'h100;
  logic          in_ready;
  logic          in_valid = 1'b0;
  logic          in_head = 1'b0;
  logic          in_tail = 1'b0;
  logic [63:0]   in_egress_id = '0;
  logic [63:0]   in_unique_id = '0;
  logic          out_valid;
  logic          out_head;
  logic          out_tail;
  logic [63:0]   out_egress_id;
  logic [63:0]   out_unique_id;
  logic [63:0]   out_inject_cycle;
  logic          credit_return = 1'b0;
  logic [CW-1:0] credits_avail;
  logic          protocol_error;
  logic          credit_overflow;
  logic [63:0]   flits_sent;

  traffic_eval_ingress_adapter #(
    .FIFO_DEPTH  (DEPTH),
    .NUM_CREDITS (NC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .current_cycle    (current_cycle),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_head          (in_head),
    .in_tail          (in_tail),
    .in_egress_id     (in_egress_id),
    .in_unique_id     (in_unique_id),
    .out_valid        (out_valid),
    .out_head         (out_head),
    .out_tail         (out_tail),
    .out_egress_id    (out_egress_id),
    .out_unique_id    (out_unique_id),
    .out_inject_cycle (out_inject_cycle),
    .credit_return    (credit_return),
    .credits_avail    (credits_avail),
    .protocol_error   (protocol_error),
    .credit_overflow  (credit_overflow),
    .flits_sent       (flits_sent)
  );

  always #5 clock = ~clock;
  always @(posedge clock) current_cycle <= current_cycle + 64'd1;

  typedef struct {
    logic        h;
    logic        t;
    logic [63:0] eg;
    logic [63:0] uid;
    logic [63:0] cyc;
  } exp_t;

  exp_t        q[$];
  int          cred = NC;
  logic        perr = 1'b0;
  logic        ovf = 1'b0;
  logic        in_pkt = 1'b0;
  logic [63:0] peg = '0;
  logic [63:0] sent = '0;
  logic        started = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  // Framing rules applied to every handshaken flit.
  function automatic void model_accept(logic h, logic t,
                                       logic [63:0] eg,
                                       logic [63:0] uid,
                                       logic [63:0] cyc);
    if (!in_pkt) begin
      if (!h) perr = 1'b1;
      else begin
        q.push_back('{h, t, eg, uid, cyc});
        if (!t) begin
          in_pkt = 1'b1;
          peg    = eg;
        end
      end
    end else if (h || eg != peg) begin
      perr   = 1'b1;
      in_pkt = 1'b0;
    end else begin
      q.push_back('{h, t, eg, uid, cyc});
      if (t) in_pkt = 1'b0;
    end
  endfunction

  // Monitor: compare every cycle, pop scoreboard on each send.
  always @(negedge clock) begin : mon
    exp_t e;
    logic ev;
    if (reset && started) begin
      ev = (q.size() != 0) && (cred != 0);
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("credits", 64'(credits_avail), 64'(cred));
      chk("protocol_error", 64'(protocol_error), 64'(perr));
      chk("credit_overflow", 64'(credit_overflow), 64'(ovf));
      chk("flits_sent", flits_sent, sent);
      if (ev && out_valid) begin
        e = q.pop_front();
        chk("out_head", 64'(out_head), 64'(e.h));
        chk("out_tail", 64'(out_tail), 64'(e.t));
        chk("out_egress", out_egress_id, e.eg);
        chk("out_uid", out_unique_id, e.uid);
        chk("out_inject", out_inject_cycle, e.cyc);
      end else if (ev) begin
        void'(q.pop_front());
      end
      if (ev) sent = sent + 64'd1;
      if (ev && !credit_return) cred--;
      else if (!ev && credit_return) begin
        if (cred == NC) ovf = 1'b1;
        else cred++;
      end
    end
  end

  // One clock of stimulus; called and returns at posedge+1.
  task automatic step(input logic v, input logic h, input logic t,
                      input logic [63:0] eg, input logic [63:0] uid,
                      input logic ret, output logic acc);
    logic [63:0] cyc;
    in_valid      = v;
    in_head       = h;
    in_tail       = t;
    in_egress_id  = eg;
    in_unique_id  = uid;
    credit_return = ret;
    @(negedge clock);
    acc = v && in_ready;
    cyc = current_cycle;
    @(posedge clock);
    if (acc) model_accept(h, t, eg, uid, cyc);
    #1;
    in_valid      = 1'b0;
    credit_return = 1'b0;
  endtask

  task automatic send(input logic h, input logic t,
                      input logic [63:0] eg, input logic [63:0] uid);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step(1, h, t, eg, uid, 0, acc);
    chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic ret_pulse(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 60 && !(q.size() == 0 && cred == NC); i++)
      step(0, 0, 0, 0, 0, cred < NC, acc);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_head", 64'(out_head), 64'd0);
    chk("rst_out_egress", out_egress_id, 64'd0);
    chk("rst_out_uid", out_unique_id, 64'd0);
    chk("rst_out_inject", out_inject_cycle, 64'd0);
    chk("rst_credits", 64'(credits_avail), 64'(NC));
    chk("rst_perr", 64'(protocol_error), 64'd0);
    chk("rst_ovf", 64'(credit_overflow), 64'd0);
    chk("rst_sent", flits_sent, 64'd0);
    q.delete();
    cred    = NC;
    perr    = 1'b0;
    ovf     = 1'b0;
    in_pkt  = 1'b0;
    sent    = '0;
    started = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic acc;
    int   cnt;
    @(posedge clock);
    #1;
    do_reset();

    for (int i = 1; i <= 6; i++) send(1, 1, 64'd1, 64'(i));
    idle(3);
    chk("single_cred_zero", 64'(credits_avail), 64'd0);
    chk("single_stalled", 64'(out_valid), 64'd0);
    ret_pulse(2);
    idle(3);
    chk("single_sent6", flits_sent, 64'd6);
    ret_pulse(4);

    send(1, 0, 64'd7, {$urandom, $urandom});
    send(0, 0, 64'd7, {$urandom, $urandom});
    send(0, 1, 64'd7, {$urandom, $urandom});
    idle(4);
    chk("pkt3_no_err", 64'(protocol_error), 64'd0);

    send(0, 1, 64'd3, 64'hbad0);
    idle(2);
    chk("body_in_idle_err", 64'(protocol_error), 64'd1);
    send(1, 0, 64'd3, 64'hc1);
    send(0, 0, 64'd5, 64'hbad1);
    send(0, 1, 64'd3, 64'hbad2);
    idle(3);
    ret_pulse(4);
    idle(2);

    ret_pulse(1);
    idle(1);
    chk("ovf_set", 64'(credit_overflow), 64'd1);
    chk("ovf_hold", 64'(credits_avail), 64'(NC));
    send(1, 1, 64'd2, 64'hd0);
    step(0, 0, 0, 0, 0, 1, acc);
    idle(1);
    chk("send_and_ret", 64'(credits_avail), 64'(NC));

    for (int i = 0; i < NC; i++) send(1, 1, 64'd4, 64'(16 + i));
    idle(4);
    cnt = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      step(1, 1, 1, 64'd4, 64'(32 + i), 0, acc);
      if (acc) cnt++;
    end
    chk("bp_accepts", 64'(cnt), 64'(DEPTH));
    ret_pulse(1);
    chk("bp_full_hold", 64'(in_ready), 64'd0);
    idle(1);
    chk("bp_slot_free", 64'(in_ready), 64'd1);
    drain();

    for (int i = 0; i < NC; i++) send(1, 1, 64'd8, 64'(64 + i));
    idle(4);
    send(1, 1, 64'd9, 64'h90);
    send(1, 0, 64'd9, 64'h91);
    do_reset();
    send(1, 0, 64'd11, 64'hb0);
    send(0, 0, 64'd11, 64'hb1);
    send(0, 1, 64'd11, 64'hb2);
    idle(5);
    chk("post_rst_no_err", 64'(protocol_error), 64'd0);
    chk("post_rst_sent", flits_sent, 64'd3);

    for (int i = 0; i < 120; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) != 0, 64'($urandom_range(0, 2)),
           {$urandom, $urandom}, $urandom_range(0, 2) == 0, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_eval_ingress_adapter.md
# traffic_eval_ingress_adapter

Synthesizable stage directly downstream of the DPI-driven traffic-eval ingress source. It accepts the source's valid/ready flit stream and buffers it in a small FIFO. It drives one NoC ingress port under credit-based flow control, stamps each flit with its acceptance cycle, and checks packet framing (head/tail, constant egress id per packet).

## Interface
Parameters:
- FIFO_DEPTH, 4: flit buffer entries; power of two, ≥2.
- NUM_CREDITS, 4: downstream input-buffer depth; initial credit count, ≥1.
- CW, $clog2(NUM_CREDITS+1): credit counter width (derived).

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- current_cycle  in  64  free-running cycle count.
- in_ready  out  1  flit accepted when in_valid && in_ready.
- in_valid / in_head / in_tail  in  1 each  source flit strobe and framing.
- in_egress_id  in  64  destination egress.
- in_unique_id  in  64  flit tag.
- out_valid  out  1  flit sent this cycle; no ready, credit-gated.
- out_head / out_tail  out  1 each  framing of sent flit.
- out_egress_id / out_unique_id  out  64 each  passed through unchanged.
- out_inject_cycle  out  64  current_cycle value captured at acceptance.
- credit_return  in  1  one credit returned per cycle high.
- credits_avail  out  CW  current credit count.
- protocol_error  out  1  sticky framing error.
- credit_overflow  out  1  sticky: credit returned while count == NUM_CREDITS.
- flits_sent  out  64  count of out_valid cycles.

## Operation
- in_ready = reset deasserted && FIFO not full; depends on registered state only, never on in_valid.
- The packet FSM observes accepted flits. State: IDLE or BODY, plus a 64-bit pkt_egress register.
  - IDLE, head&&tail: push the flit; stay in IDLE.
  - IDLE, head&&!tail: push; latch pkt_egress; go to BODY.
  - IDLE, !head: error; drop the flit; stay in IDLE.
  - BODY, !head with egress == pkt_egress: push; a tail returns the FSM to IDLE.
  - BODY, head or egress mismatch: error; drop the flit; go to IDLE.
- A dropped flit is still handshaken (in_ready was high), so the source never stalls on an error. An error sets protocol_error, which holds until reset.
- FIFO entry = {head, tail, egress_id, unique_id, inject_cycle}.
- out_valid = FIFO not empty && credits_avail != 0. A cycle with out_valid high pops the FIFO, decrements credits, and increments flits_sent; flits_sent wraps at 2^64.
- Credits:
  - send only: −1.
  - credit_return only: +1.
  - both in the same cycle: unchanged.
  - credit_return at NUM_CREDITS with no send: count holds, credit_overflow set (sticky).
- Out payload fields are valid only when out_valid = 1; they hold the FIFO head entry otherwise.

## Timing
- Reset values:
  - in_ready 0 (while reset is asserted); out_valid 0; out_* payload 0.
  - credits_avail NUM_CREDITS; protocol_error 0; credit_overflow 0; flits_sent 0.
  - FSM in IDLE; FIFO empty.
- Latency: a flit accepted in cycle N can appear on out_valid no earlier than N+1. There is no combinational in→out path.
- Throughput: one flit per cycle when credits are sufficient.
- Full FIFO: in_ready = 0 even if a pop occurs in the same cycle; the freed slot is visible at N+1.
- Empty FIFO with a push in the same cycle: out_valid stays 0 in that cycle.
- credit_return in cycle N is counted from N+1. With credits_avail = 0 in N, the earliest send is N+1.
- Reset asserted mid-packet: FIFO contents are discarded, the FSM returns to IDLE, and credits are restored to NUM_CREDITS.

## Structure
- Package traffic_eval_pkg holds:
  - typedef flit_t {head, tail, egress_id[63:0], unique_id[63:0]}.
  - typedef entry_t {flit_t, inject_cycle[63:0]}.
  - enum pkt_state_e {IDLE, BODY}.
- Sub-module traffic_eval_fifo: parameterized on entry_t and FIFO_DEPTH; push/pop/full/empty. Pointers carry one extra wrap bit to distinguish full from empty.
- The top level contains the packet FSM, credit counter, counters and sticky flags.

## Test plan
- Single-flit packets, with NUM_CREDITS=4, credit_return tied 0:
  - stimulus: 6 back-to-back single-flit packets (head=tail=1), ids 1..6.
  - required: out_valid for ids 1–4 in consecutive cycles, then out_valid 0 and credits_avail 0.
  - after 2 credit_return pulses: ids 5 and 6 emitted; flits_sent = 6.
- 3-flit packet, egress 7:
  - required: in order head/body/tail on out; out_inject_cycle equals current_cycle at each accept.
  - required: protocol_error stays 0.
- Framing errors:
  - body flit in IDLE → dropped, protocol_error = 1.
  - head(egress 3) followed by body(egress 5) → body dropped, FSM in IDLE.
- Back-pressure: with credits held at 0, push until in_ready = 0 after exactly FIFO_DEPTH accepts. Then return 1 credit → one pop, and in_ready = 1 in the following cycle.
- Credit edge cases:
  - credit_return and a send in the same cycle → credits_avail unchanged.
  - credit_return at full credit → credit_overflow = 1 and count stays at NUM_CREDITS.
- Reset mid-packet: assert reset after a head flit with 2 flits buffered. Required: all outputs at reset values immediately; after release, a fresh packet passes with no error.
